// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// This unit predicts control flow in IF and resolves it in EX. It uses a
// direct-mapped branch target buffer (BTB). Each BTB entry holds a valid bit,
// a tag, a target and a saturating direction counter.
//
// IF lookup (combinational from if_pc):
//   idx = if_pc[2 +: IDX_W]
//   tag = if_pc[IDX_W+2 +: TAG_W]
//   The unit predicts taken when the entry hits and the counter MSB is set.
//
// EX resolution (combinational):
//   The resolver handles jal, jalr and the six defined B-type conditions,
//   including bltu and bgeu. It compares the outcome with the prediction
//   that was piped down with the instruction. On a mismatch it raises
//   redirect for the same cycle.
//
// The BTB and the statistics counters update on the next rising edge.
//
// Ports
//   clk, rst           clock (rising edge); synchronous active-high reset
//   if_pc              fetch PC
//   pred_taken         IF prediction: taken
//   pred_target        IF predicted next PC
//   ex_valid           EX holds a real instruction
//   ex_pc              EX instruction PC
//   ex_jump            00 none, 01 jal, 10 jalr, 11 none
//   ex_branch_en       EX instruction is a B-type branch
//   ex_func3           branch condition select
//   ex_zero            rs1 == rs2
//   ex_neg             signed rs1 < rs2
//   ex_ltu             unsigned rs1 < rs2
//   ex_target          resolved target address
//   ex_pred_taken      prediction piped down with the instruction
//   ex_pred_target     predicted target piped down with the instruction
//   redirect           mispredict: flush IF/ID and load redirect_pc
//   redirect_pc        correct next PC; 0 when nothing resolves
//   stat_branches      resolved control-flow instructions (saturating)
//   stat_mispred       mispredictions (saturating)
//
// Handshake
//   There is no valid/ready pair. ex_valid qualifies the EX inputs in the
//   cycle they are presented. redirect is meaningful in that same cycle
//   and needs no acknowledge.
// ---------------------------------------------------------------------------
module branch_predict_unit #(
   parameter int ADDR_W  = 32,
   parameter int ENTRIES = 64,
   parameter int TAG_W   = 8,
   parameter int CTR_W   = 2,
   parameter int STAT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] if_pc,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              ex_valid,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic [1:0]        ex_jump,
   input  logic              ex_branch_en,
   input  logic [2:0]        ex_func3,
   input  logic              ex_zero,
   input  logic              ex_neg,
   input  logic              ex_ltu,
   input  logic [ADDR_W-1:0] ex_target,
   input  logic              ex_pred_taken,
   input  logic [ADDR_W-1:0] ex_pred_target,
   output logic              redirect,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispred
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
   localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

   // BTB storage
   logic              r_valid [ENTRIES];
   logic [TAG_W-1:0]  r_tag   [ENTRIES];
   logic [ADDR_W-1:0] r_tgt   [ENTRIES];
   logic [CTR_W-1:0]  r_ctr   [ENTRIES];

   logic [STAT_W-1:0] r_stat_br;
   logic [STAT_W-1:0] r_stat_mp;

   // ------------------------------------------------------------------
   // IF lookup. The lookup reads the registered contents only, so an
   // update to the same index in this cycle becomes visible one cycle
   // later.
   // ------------------------------------------------------------------
   logic [IDX_W-1:0] w_if_idx;
   logic [TAG_W-1:0] w_if_tag;
   logic             w_if_hit;

   assign w_if_idx = if_pc[2 +: IDX_W];
   assign w_if_tag = if_pc[IDX_W+2 +: TAG_W];
   assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

   assign pred_taken  = !rst && w_if_hit && r_ctr[w_if_idx][CTR_W-1];
   assign pred_target = pred_taken ? r_tgt[w_if_idx] : (if_pc + ADDR_W'(4));

   // ------------------------------------------------------------------
   // EX resolution
   // ------------------------------------------------------------------
   logic              w_is_jump;
   logic              w_br_cond;
   logic              w_f3_ok;
   logic              w_resolved;
   logic              w_taken;
   logic [ADDR_W-1:0] w_actual_pc;
   logic              w_mispred;

   // Encoding 11 behaves exactly like 00 (not a jump).
   assign w_is_jump = (ex_jump == 2'b01) || (ex_jump == 2'b10);

   always_comb begin
      w_br_cond = 1'b0;
      w_f3_ok   = 1'b1;
      case (ex_func3)
         3'b000:  w_br_cond = ex_zero;
         3'b001:  w_br_cond = !ex_zero;
         3'b100:  w_br_cond = ex_neg;
         3'b101:  w_br_cond = !ex_neg;
         3'b110:  w_br_cond = ex_ltu;
         3'b111:  w_br_cond = !ex_ltu;
         default: w_f3_ok   = 1'b0;   // 010/011: not a control-flow op here
      endcase
   end

   // A jump takes priority over ex_branch_en.
   assign w_resolved  = ex_valid && !rst && (w_is_jump || (ex_branch_en && w_f3_ok));
   assign w_taken     = w_is_jump || w_br_cond;
   assign w_actual_pc = w_taken ? ex_target : (ex_pc + ADDR_W'(4));

   // When the direction is correctly predicted taken, a target mismatch is
   // still a mispredict.
   assign w_mispred = w_resolved &&
                      ((w_taken != ex_pred_taken) ||
                       (w_taken && (ex_pred_target != ex_target)));

   assign redirect    = w_mispred;
   assign redirect_pc = w_resolved ? w_actual_pc : '0;

   // ------------------------------------------------------------------
   // EX-side BTB probe for the update
   // ------------------------------------------------------------------
   logic [IDX_W-1:0] w_ex_idx;
   logic [TAG_W-1:0] w_ex_tag;
   logic             w_ex_hit;

   assign w_ex_idx = ex_pc[2 +: IDX_W];
   assign w_ex_tag = ex_pc[IDX_W+2 +: TAG_W];
   assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

   // ------------------------------------------------------------------
   // Table and statistics update
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_tag[i]   <= '0;
            r_tgt[i]   <= '0;
            r_ctr[i]   <= '0;
         end
         r_stat_br <= '0;
         r_stat_mp <= '0;
      end else if (w_resolved) begin
         if (w_ex_hit) begin
            if (w_is_jump) begin
               r_ctr[w_ex_idx] <= CTR_MAX;
            end else if (w_taken) begin
               if (r_ctr[w_ex_idx] != CTR_MAX) begin
                  r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + CTR_W'(1);
               end
            end else begin
               if (r_ctr[w_ex_idx] != '0) begin
                  r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - CTR_W'(1);
               end
            end
            if (w_taken) begin
               r_tgt[w_ex_idx] <= ex_target;
            end
         end else if (w_taken) begin
            // On a miss, only a taken instruction allocates. The new entry
            // replaces whatever tag occupied this index.
            r_valid[w_ex_idx] <= 1'b1;
            r_tag[w_ex_idx]   <= w_ex_tag;
            r_tgt[w_ex_idx]   <= ex_target;
            r_ctr[w_ex_idx]   <= w_is_jump ? CTR_MAX : CTR_WEAK;
         end

         if (r_stat_br != STAT_MAX) begin
            r_stat_br <= r_stat_br + STAT_W'(1);
         end
         if (w_mispred && (r_stat_mp != STAT_MAX)) begin
            r_stat_mp <= r_stat_mp + STAT_W'(1);
         end
      end
   end

   assign stat_branches = r_stat_br;
   assign stat_mispred  = r_stat_mp;

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
//
// This bench drives two instances from the same inputs: one with default
// parameters, and one with 4-bit statistics so that saturation is reachable.
// A behavioural BTB model, held in plain arrays, predicts every output on
// every cycle. Directed literal expectations pin down the model itself.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

   localparam int ENTRIES = 64;
   localparam int IDX_W   = 6;
   localparam int TAG_W   = 8;
   localparam int CTR_MAX = 3;      // CTR_W = 2
   localparam int CTR_MSB = 2;      // counter value at which MSB is set

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [1:0]  ex_jump;
   logic        ex_branch_en;
   logic [2:0]  ex_func3;
   logic        ex_zero, ex_neg, ex_ltu;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;

   logic        pred_taken, redirect;
   logic [31:0] pred_target, redirect_pc;
   logic [15:0] stat_branches, stat_mispred;

   logic        s_pred_taken, s_redirect;
   logic [31:0] s_pred_target, s_redirect_pc;
   logic [3:0]  s_stat_branches, s_stat_mispred;

   always #5 clk = ~clk;

   branch_predict_unit dut (
      .clk(clk), .rst(rst), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_jump(ex_jump),
      .ex_branch_en(ex_branch_en), .ex_func3(ex_func3),
      .ex_zero(ex_zero), .ex_neg(ex_neg), .ex_ltu(ex_ltu),
      .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
      .ex_pred_target(ex_pred_target),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .stat_branches(stat_branches), .stat_mispred(stat_mispred)
   );

   branch_predict_unit #(.STAT_W(4)) dut_s (
      .clk(clk), .rst(rst), .if_pc(if_pc),
      .pred_taken(s_pred_taken), .pred_target(s_pred_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_jump(ex_jump),
      .ex_branch_en(ex_branch_en), .ex_func3(ex_func3),
      .ex_zero(ex_zero), .ex_neg(ex_neg), .ex_ltu(ex_ltu),
      .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
      .ex_pred_target(ex_pred_target),
      .redirect(s_redirect), .redirect_pc(s_redirect_pc),
      .stat_branches(s_stat_branches), .stat_mispred(s_stat_mispred)
   );

   // ---------------- behavioural model ----------------
   bit          m_valid [ENTRIES];
   int          m_tag   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];
   int          m_br, m_mp, m_br4, m_mp4;

   logic        e_pred_taken, e_redirect, e_resolved, e_taken, e_is_jump;
   logic [31:0] e_pred_target, e_redirect_pc;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   function automatic int pc_idx(input logic [31:0] pc);
      return int'(pc >> 2) % ENTRIES;
   endfunction

   function automatic int pc_tag(input logic [31:0] pc);
      return int'(pc >> (IDX_W + 2)) % (1 << TAG_W);
   endfunction

   function automatic void lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
      int i;
      i  = pc_idx(pc);
      t  = m_valid[i] && (m_tag[i] == pc_tag(pc)) && (m_ctr[i] >= CTR_MSB);
      tg = t ? m_tgt[i] : pc + 32'd4;
   endfunction

   task automatic model_eval();
      logic cond_ok, cond;
      lookup(if_pc, e_pred_taken, e_pred_target);
      if (rst) begin
         e_pred_taken  = 1'b0;
         e_pred_target = if_pc + 32'd4;
      end
      e_is_jump = (ex_jump == 2'd1) || (ex_jump == 2'd2);
      cond_ok = 1'b1;
      cond    = 1'b0;
      case (ex_func3)
         3'd0: cond = ex_zero;
         3'd1: cond = !ex_zero;
         3'd4: cond = ex_neg;
         3'd5: cond = !ex_neg;
         3'd6: cond = ex_ltu;
         3'd7: cond = !ex_ltu;
         default: cond_ok = 1'b0;
      endcase
      e_resolved    = ex_valid && !rst && (e_is_jump || (ex_branch_en && cond_ok));
      e_taken       = e_is_jump || cond;
      e_redirect    = e_resolved && ((e_taken != ex_pred_taken) ||
                                     (e_taken && ex_pred_target != ex_target));
      e_redirect_pc = !e_resolved ? 32'd0 : (e_taken ? ex_target : ex_pc + 32'd4);
   endtask

   task automatic model_update();
      int i;
      bit hit;
      if (rst) begin
         for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 0;
         end
         m_br = 0; m_mp = 0; m_br4 = 0; m_mp4 = 0;
      end else if (e_resolved) begin
         i   = pc_idx(ex_pc);
         hit = m_valid[i] && (m_tag[i] == pc_tag(ex_pc));
         if (hit) begin
            if (e_is_jump)    m_ctr[i] = CTR_MAX;
            else if (e_taken) m_ctr[i] = (m_ctr[i] + 1 > CTR_MAX) ? CTR_MAX : m_ctr[i] + 1;
            else              m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            if (e_taken) m_tgt[i] = ex_target;
         end else if (e_taken) begin
            m_valid[i] = 1;
            m_tag[i]   = pc_tag(ex_pc);
            m_tgt[i]   = ex_target;
            m_ctr[i]   = e_is_jump ? CTR_MAX : CTR_MSB;
         end
         m_br  = (m_br  < 65535) ? m_br  + 1 : m_br;
         m_br4 = (m_br4 < 15)    ? m_br4 + 1 : m_br4;
         if (e_redirect) begin
            m_mp  = (m_mp  < 65535) ? m_mp  + 1 : m_mp;
            m_mp4 = (m_mp4 < 15)    ? m_mp4 + 1 : m_mp4;
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Called with inputs already driven (just after a posedge): compare at negedge,
   // then advance the model at the edge the DUT uses.
   task automatic step();
      model_eval();
      @(negedge clk);
      check("pred_taken",    32'(pred_taken),      32'(e_pred_taken));
      check("pred_target",   pred_target,          e_pred_target);
      check("redirect",      32'(redirect),        32'(e_redirect));
      check("redirect_pc",   redirect_pc,          e_redirect_pc);
      check("stat_branches", 32'(stat_branches),   32'(m_br));
      check("stat_mispred",  32'(stat_mispred),    32'(m_mp));
      check("s_stat_br",     32'(s_stat_branches), 32'(m_br4));
      check("s_stat_mp",     32'(s_stat_mispred),  32'(m_mp4));
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic idle(input logic [31:0] pc);
      rst = 1'b0; if_pc = pc; ex_valid = 1'b0; ex_pc = '0; ex_jump = 2'd0;
      ex_branch_en = 1'b0; ex_func3 = 3'd0; ex_zero = 1'b0; ex_neg = 1'b0;
      ex_ltu = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
   endtask

   task automatic drive_br(input logic [31:0] pc, input logic [2:0] f3, input logic z,
                           input logic n, input logic l, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptg);
      ex_valid = 1'b1; ex_pc = pc; ex_jump = 2'd0; ex_branch_en = 1'b1;
      ex_func3 = f3; ex_zero = z; ex_neg = n; ex_ltu = l; ex_target = tgt;
      ex_pred_taken = pt; ex_pred_target = ptg;
   endtask

   function automatic logic [31:0] rand_pc();
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) return 32'hFFFF_FFFC;
      if (sel == 1) return $urandom & 32'hFFFF_FFFC;
      return (32'($urandom_range(0, 2)) << (IDX_W + 2)) | (32'($urandom_range(0, 3)) << 2);
   endfunction

   initial begin
      logic        lt;
      logic [31:0] ltg;
      idle(32'h100);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // reset cycle, then first lookup misses
      step();
      idle(32'h100);
      #1;
      check("lit_reset_pred",   32'(pred_taken),    32'd0);
      check("lit_reset_tgt",    pred_target,        32'h104);
      check("lit_reset_br",     32'(stat_branches), 32'd0);
      check("lit_reset_mp",     32'(stat_mispred),  32'd0);
      step();

      // beq taken, predicted not taken: allocate weakly taken
      drive_br(32'h100, 3'd0, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
      #1;
      check("lit_beq_redir",    32'(redirect), 32'd1);
      check("lit_beq_rpc",      redirect_pc,   32'h80);
      check("lit_beq_nobypass", 32'(pred_taken), 32'd0);
      step();
      idle(32'h100);
      #1;
      check("lit_alloc_pred",   32'(pred_taken),    32'd1);
      check("lit_alloc_tgt",    pred_target,        32'h80);
      check("lit_alloc_mp",     32'(stat_mispred),  32'd1);
      step();

      // counter 10 -> 01 -> 00
      drive_br(32'h100, 3'd0, 1'b0, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
      #1;
      check("lit_nt1_redir", 32'(redirect), 32'd1);
      check("lit_nt1_rpc",   redirect_pc,   32'h104);
      step();
      drive_br(32'h100, 3'd0, 1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
      #1;
      check("lit_nt2_redir", 32'(redirect), 32'd0);
      check("lit_nt2_rpc",   redirect_pc,   32'h104);
      step();
      idle(32'h100);
      #1;
      check("lit_nt_pred", 32'(pred_taken), 32'd0);
      step();
      // saturate at 0, then one taken: 00 -> 00 -> 01, still not taken
      drive_br(32'h100, 3'd0, 1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
      step();
      drive_br(32'h100, 3'd0, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
      step();
      idle(32'h100);
      #1;
      check("lit_sat0_pred", 32'(pred_taken),    32'd0);
      check("lit_sat0_br",   32'(stat_branches), 32'd5);
      check("lit_sat0_mp",   32'(stat_mispred),  32'd3);
      step();

      // unsigned vs signed compare
      drive_br(32'h400, 3'd6, 1'b0, 1'b0, 1'b1, 32'h480, 1'b0, 32'h404);
      #1;
      check("lit_bltu_redir", 32'(redirect), 32'd1);
      check("lit_bltu_rpc",   redirect_pc,   32'h480);
      step();
      drive_br(32'h500, 3'd4, 1'b0, 1'b0, 1'b1, 32'h580, 1'b0, 32'h504);
      #1;
      check("lit_blt_redir", 32'(redirect), 32'd0);
      step();

      // jalr with wrong predicted target
      idle(32'h200);
      ex_valid = 1'b1; ex_pc = 32'h200; ex_jump = 2'd2; ex_target = 32'h340;
      ex_pred_taken = 1'b1; ex_pred_target = 32'h300;
      #1;
      check("lit_jalr_redir", 32'(redirect), 32'd1);
      check("lit_jalr_rpc",   redirect_pc,   32'h340);
      step();
      idle(32'h200);
      #1;
      check("lit_jalr_pred", 32'(pred_taken), 32'd1);
      check("lit_jalr_tgt",  pred_target,     32'h340);
      step();
      idle(32'h100);   // aliases idx 0, now owned by 0x200
      #1;
      check("lit_alias_pred", 32'(pred_taken), 32'd0);
      step();

      // 20 mispredicted jal: 4-bit statistics saturate
      for (int k = 0; k < 20; k++) begin
         idle(32'h600);
         ex_valid = 1'b1; ex_pc = 32'h600; ex_jump = 2'd1; ex_target = 32'h700;
         step();
      end
      drive_br(32'h100, 3'd2, 1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
      #1;
      check("lit_f3_010_redir", 32'(redirect), 32'd0);
      step();
      idle(32'h600);
      #1;
      check("lit_sat_s_mp", 32'(s_stat_mispred), 32'd15);
      check("lit_sat_br",   32'(stat_branches),  32'd28);
      check("lit_sat_mp",   32'(stat_mispred),   32'd25);
      step();

      // randomized traffic, occasional reset mid-operation
      for (int k = 0; k < 3000; k++) begin
         idle(rand_pc());
         rst      = ($urandom_range(0, 149) == 0);
         ex_valid = ($urandom_range(0, 9) < 8);
         ex_pc    = rand_pc();
         ex_jump  = 2'($urandom_range(0, 5) < 4 ? 0 : $urandom_range(1, 3));
         ex_branch_en = (ex_jump == 2'd3) ? 1'b0 : 1'($urandom_range(0, 1));
         ex_func3 = 3'($urandom_range(0, 7));
         ex_zero  = 1'($urandom_range(0, 1));
         ex_neg   = 1'($urandom_range(0, 1));
         ex_ltu   = 1'($urandom_range(0, 1));
         ex_target = rand_pc();
         if ($urandom_range(0, 1) == 1) begin
            lookup(ex_pc, lt, ltg);
            ex_pred_taken = lt; ex_pred_target = ltg;
         end else begin
            ex_pred_taken = 1'($urandom_range(0, 1)); ex_pred_target = rand_pc();
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
